modn_updown_counter: RTL and testbench
======================================

Name: modn_updown_counter

Overview:
- Parametrised successor to the team's basic up-counter: modulo-N up/down counter with parallel load, programmable step, terminal-count pulse and zero flag.
- Used as a building block for decade counters, clock dividers and display sequencing in the lab designs.
- Cascadable: the `tc` output of one instance drives `en` of the next instance.

Parameters:
- WIDTH, 8, bit width of `count` and `v`.
- MAX, 255, highest count value; the counter runs modulo MAX+1. Constraint: 1 <= MAX <= 2^WIDTH-1.
- STEP, 1, increment/decrement magnitude per enabled cycle. Constraint: 1 <= STEP <= MAX.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserted when 0, asynchronously; release is sampled on `clk`.
- en  input  1  count enable: one step per cycle while high.
- ld  input  1  parallel load strobe.
- dir  input  1  direction: 1 = up, 0 = down.
- v  input  WIDTH  load value.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- zero  output  1  high when `count` == 0, registered.

Behaviour:
- Reset (rst=0, asynchronous): `count`=0, `tc`=0, `zero`=1, immediately and without waiting for a clock edge.
- Priority at each rising edge: rst > ld > en > hold.
- Load (ld=1):
  - `count` <= min(v, MAX).
  - `tc` <= 0.
  - `en` and `dir` are ignored that cycle.
- Up step (en=1, dir=1):
  - Sum is computed at WIDTH+1 bits, so there is no intermediate overflow.
  - If count+STEP > MAX: `count` <= count+STEP-(MAX+1) and `tc` <= 1 (wrap).
  - Else: `count` <= count+STEP and `tc` <= 0.
- Down step (en=1, dir=0):
  - If count < STEP: `count` <= count+(MAX+1)-STEP and `tc` <= 1 (wrap).
  - Else: `count` <= count-STEP and `tc` <= 0.
- Hold (en=0, ld=0): `count` unchanged, `tc` <= 0.
- `tc` rules:
  - Single-cycle pulse, asserted in the cycle after the wrapping edge, aligned with the wrapped `count` value.
  - Never asserted for two consecutive cycles unless a wrap occurs on each of those edges.
- `zero`: registered, updated on the same edge as `count`; it always equals (`count` == 0).
- Latency: one clock from `ld`/`en` sampled to the new `count`/`tc`/`zero`.
- `dir` may change on any cycle; it takes effect at the next enabled edge.
- Reset mid-operation overrides everything. After release, counting resumes from 0 on the first enabled edge.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- When defined:
  - An extra input port `sat` (1 bit) is added after `dir`.
  - When `sat`=1, the up direction clamps at MAX instead of wrapping, and the down direction clamps at 0.
  - `tc` <= 1 on any enabled edge where a clamp limits the result, including while the counter is already sitting at the limit.
  - When `sat`=0, behaviour is identical to the wrap mode.
- When undefined: no `sat` port; the counter always wraps as described above.

Test Plan:
- Reset: drive rst=0 mid-count with count=5, no clock edge -> count=0, zero=1, tc=0 immediately.
- Decade count (WIDTH=4, MAX=9, STEP=1): en=1, dir=1 from 0 for 10 cycles -> count 1..9 then 0; tc=1 only in the cycle count returns to 0.
- Down wrap with step (MAX=9, STEP=3): load 1, en=1, dir=0 -> count 8 with tc=1, then 5, 2, 9 with tc=1.
- Load priority and clip (MAX=9): ld=1, en=1, v=12 -> count=9, tc=0. Next: ld=1, v=0 -> count=0, zero=1.
- Hold and direction change: en=0 for 3 cycles at count=4 -> count stays 4, tc=0. Then dir toggles 1,0,1 with en=1 -> count 5, 4, 5.
- COUNTER_SAT_EN defined, sat=1, MAX=9: count=8, up for 3 cycles -> count 9, 9, 9 with tc=0, 1, 1. Then dir=0 from 1 -> count 0 then 0 with tc=0, then tc=1.

Source files
------------

// File: rtl/modn_updown_counter.sv
//==============================================================================
// Module   : modn_updown_counter
// Brief    : Modulo-(MAX+1) up/down counter with parallel load, programmable
//            step, registered terminal-count pulse and registered zero flag.
//            Optional macro COUNTER_SAT_EN adds a 'sat' input that makes the
//            counter clamp at MAX / 0 instead of wrapping.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module modn_updown_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic             dir,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    // Limits and wrap adjustments. All wrapped results are <= MAX, so they
    // fit in WIDTH bits even though the wrap test itself needs WIDTH+1 bits.
    localparam logic [WIDTH:0]   c_MAX_EXT  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] c_MAX      = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_STEP     = WIDTH'(STEP);
    localparam logic [WIDTH:0]   c_STEP_EXT = (WIDTH+1)'(STEP);
    // count + STEP - (MAX+1), evaluated modulo 2^WIDTH
    localparam logic [WIDTH-1:0] c_UP_WRAP  = WIDTH'(STEP - MAX - 1);
    // count + (MAX+1) - STEP
    localparam logic [WIDTH-1:0] c_DN_WRAP  = WIDTH'(MAX + 1 - STEP);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_zero;

    logic [WIDTH:0]   w_sum_ext;
    logic             w_up_over;
    logic             w_dn_under;
    logic             w_sat;
    logic [WIDTH-1:0] w_next;
    logic             w_next_tc;

`ifdef COUNTER_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif

    // Up sum carried one bit wider so count+STEP cannot overflow before compare
    assign w_sum_ext  = {1'b0, r_count} + c_STEP_EXT;
    assign w_up_over  = (w_sum_ext > c_MAX_EXT);
    assign w_dn_under = (r_count < c_STEP);

    // Next-state selection: load beats enable, enable beats hold
    always_comb begin
        w_next    = r_count;
        w_next_tc = 1'b0;
        if (ld) begin
            w_next = (v > c_MAX) ? c_MAX : v;
        end else if (en) begin
            if (dir) begin
                if (w_up_over) begin
                    w_next_tc = 1'b1;
                    w_next    = w_sat ? c_MAX : (r_count + c_UP_WRAP);
                end else begin
                    w_next    = r_count + c_STEP;
                end
            end else begin
                if (w_dn_under) begin
                    w_next_tc = 1'b1;
                    w_next    = w_sat ? '0 : (r_count + c_DN_WRAP);
                end else begin
                    w_next    = r_count - c_STEP;
                end
            end
        end
    end

    // State registers; zero is registered alongside count so they stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_count <= w_next;
            r_tc    <= w_next_tc;
            r_zero  <= (w_next == '0);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_modn_updown_counter.sv
//==============================================================================
// Module   : tb_modn_updown_counter
// Brief    : Self-checking bench for modn_updown_counter. Two instances share
//            stimulus: A (WIDTH=4, MAX=9, STEP=1) and B (WIDTH=4, MAX=9,
//            STEP=3). Expected values go through a scoreboard queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_modn_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       ld  = 1'b0;
    logic       dir = 1'b0;
    logic       sat = 1'b0;
    logic [3:0] v   = 4'd0;

    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, zero_a, zero_b;

    modn_updown_counter #(.WIDTH(4), .MAX(9), .STEP(1)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .ld    (ld),
        .dir   (dir),
`ifdef COUNTER_SAT_EN
        .sat   (sat),
`endif
        .v     (v),
        .count (count_a),
        .tc    (tc_a),
        .zero  (zero_a)
    );

    modn_updown_counter #(.WIDTH(4), .MAX(9), .STEP(3)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .ld    (ld),
        .dir   (dir),
`ifdef COUNTER_SAT_EN
        .sat   (sat),
`endif
        .v     (v),
        .count (count_b),
        .tc    (tc_b),
        .zero  (zero_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld;
        logic       en;
        logic       dir;
        logic [3:0] v;
        logic [3:0] ca;
        logic       ta;
        logic [3:0] cb;
        logic       tb;
    } vec_t;

    typedef struct packed {
        logic [3:0] ca;
        logic       ta;
        logic [3:0] cb;
        logic       tb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [3:0] m_a = 4'd0;
    logic [3:0] m_b = 4'd0;

    // Reference behaviour for MAX=9, returns {tc, count}
    function automatic logic [4:0] model(input logic [3:0] c, input logic ld_i,
                                         input logic en_i, input logic dir_i,
                                         input logic sat_i, input logic [3:0] v_i,
                                         input int step);
        int s;
        if (ld_i) return {1'b0, (v_i > 4'd9) ? 4'd9 : v_i};
        if (!en_i) return {1'b0, c};
        if (dir_i) begin
            s = int'(c) + step;
            if (s > 9) return sat_i ? {1'b1, 4'd9} : {1'b1, 4'(s - 10)};
            return {1'b0, 4'(s)};
        end
        if (int'(c) < step) return sat_i ? {1'b1, 4'd0} : {1'b1, 4'(int'(c) + 10 - step)};
        return {1'b0, 4'(int'(c) - step)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic addv(input logic l, input logic e, input logic d, input logic [3:0] val,
                        input logic [3:0] ca, input logic ta, input logic [3:0] cb, input logic tb);
        vecs.push_back({l, e, d, val, ca, ta, cb, tb});
    endtask

    // Drive one cycle of inputs on the falling edge, queue the expectation,
    // then compare just after the rising edge.
    task automatic apply(input logic l, input logic e, input logic d, input logic [3:0] val,
                         input exp_t ex);
        exp_t got;
        @(negedge clk);
        ld = l; en = e; dir = d; v = val;
        sb.push_back(ex);
        m_a = ex.ca;
        m_b = ex.cb;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            chk("count_a", int'(count_a), int'(got.ca));
            chk("tc_a",    int'(tc_a),    int'(got.ta));
            chk("zero_a",  int'(zero_a),  int'(got.ca == 4'd0));
            chk("count_b", int'(count_b), int'(got.cb));
            chk("tc_b",    int'(tc_b),    int'(got.tb));
            chk("zero_b",  int'(zero_b),  int'(got.cb == 4'd0));
        end
    endtask

    task automatic apply_model(input logic l, input logic e, input logic d, input logic [3:0] val);
        logic [4:0] ra, rb;
        ra = model(m_a, l, e, d, sat, val, 1);
        rb = model(m_b, l, e, d, sat, val, 3);
        apply(l, e, d, val, {ra[3:0], ra[4], rb[3:0], rb[4]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Decade count from 0: A runs 1..9,0 ; B steps by 3 with wraps
        addv(0,1,1,0, 4'd1,0, 4'd3,0);
        addv(0,1,1,0, 4'd2,0, 4'd6,0);
        addv(0,1,1,0, 4'd3,0, 4'd9,0);
        addv(0,1,1,0, 4'd4,0, 4'd2,1);
        addv(0,1,1,0, 4'd5,0, 4'd5,0);
        addv(0,1,1,0, 4'd6,0, 4'd8,0);
        addv(0,1,1,0, 4'd7,0, 4'd1,1);
        addv(0,1,1,0, 4'd8,0, 4'd4,0);
        addv(0,1,1,0, 4'd9,0, 4'd7,0);
        addv(0,1,1,0, 4'd0,1, 4'd0,1);
        // Load 1, then count down with wraps
        addv(1,0,0,1, 4'd1,0, 4'd1,0);
        addv(0,1,0,0, 4'd0,0, 4'd8,1);
        addv(0,1,0,0, 4'd9,1, 4'd5,0);
        addv(0,1,0,0, 4'd8,0, 4'd2,0);
        addv(0,1,0,0, 4'd7,0, 4'd9,1);
        // Load beats enable and clips to MAX; then load zero
        addv(1,1,1,12, 4'd9,0, 4'd9,0);
        addv(1,0,0,0,  4'd0,0, 4'd0,0);
        // Hold at 4, then direction changes
        addv(1,0,0,4, 4'd4,0, 4'd4,0);
        addv(0,0,1,0, 4'd4,0, 4'd4,0);
        addv(0,0,0,0, 4'd4,0, 4'd4,0);
        addv(0,0,1,0, 4'd4,0, 4'd4,0);
        addv(0,1,1,0, 4'd5,0, 4'd7,0);
        addv(0,1,0,0, 4'd4,0, 4'd4,0);
        addv(0,1,1,0, 4'd5,0, 4'd7,0);

        // Reset state held while rst is low
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count_a", int'(count_a), 0);
        chk("reset_zero_a",  int'(zero_a),  1);
        chk("reset_tc_a",    int'(tc_a),    0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset mid-count, no clock edge involved
        apply(1, 0, 0, 4'd5, {4'd5, 1'b0, 4'd5, 1'b0});
        @(negedge clk);
        ld = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count_a", int'(count_a), 0);
        chk("async_rst_zero_a",  int'(zero_a),  1);
        chk("async_rst_tc_a",    int'(tc_a),    0);
        chk("async_rst_count_b", int'(count_b), 0);
        @(negedge clk);
        rst = 1'b1;
        m_a = 4'd0;
        m_b = 4'd0;

        // Table of directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ld, vecs[i].en, vecs[i].dir, vecs[i].v,
                  {vecs[i].ca, vecs[i].ta, vecs[i].cb, vecs[i].tb});
        end

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            apply_model($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                        4'($urandom_range(0, 15)));
        end

`ifdef COUNTER_SAT_EN
        // Clamp mode: sits at the limits with tc raised on each limited edge
        sat = 1'b1;
        apply(1, 0, 0, 4'd8, {4'd8, 1'b0, 4'd8, 1'b0});
        apply(0, 1, 1, 4'd0, {4'd9, 1'b0, 4'd9, 1'b1});
        apply(0, 1, 1, 4'd0, {4'd9, 1'b1, 4'd9, 1'b1});
        apply(0, 1, 1, 4'd0, {4'd9, 1'b1, 4'd9, 1'b1});
        apply(1, 0, 0, 4'd1, {4'd1, 1'b0, 4'd1, 1'b0});
        apply(0, 1, 0, 4'd0, {4'd0, 1'b0, 4'd0, 1'b1});
        apply(0, 1, 0, 4'd0, {4'd0, 1'b1, 4'd0, 1'b1});
        for (int i = 0; i < 30; i++) begin
            apply_model($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                        4'($urandom_range(0, 15)));
        end
        sat = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
